serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used by the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder producing one sum bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_full_adder (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = StAdd;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        // The last bit is folded straight into the result so sum sees all WIDTH bits.
        if (cnt_q == LastCnt) begin
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StAdd);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
  logic         prev_ovf;
`endif

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_adder #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
    int sx, sy, s;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    s  = sx + sy + int'(c);
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction
`endif

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c);
    int total;
    total = int'(x) + int'(y) + int'(c);
    check({tag, ".sum"}, sum, 64'(total % (1 << W)));
    check({tag, ".cout"}, cout, 64'(total >= (1 << W)));
    prev_sum  = W'(total % (1 << W));
    prev_cout = (total >= (1 << W));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ".ovf"}, ovf, 64'(model_ovf(x, y, c)));
    prev_ovf = model_ovf(x, y, c);
`endif
  endtask

  // Leaves the bench #1 after the edge that enters the done cycle.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    int n, bc;
    start_op(x, y, c);
    check({tag, ".busy_start"}, busy, 64'(1));
    check({tag, ".sum_hold"}, sum, 64'(prev_sum));
    wait_done(n, bc);
    check({tag, ".latency"}, 64'(n + 1), 64'(W + 1));
    check({tag, ".busy_cycles"}, 64'(bc), 64'(W));
    check({tag, ".busy_in_done"}, busy, 64'(0));
    check_result(tag, x, y, c);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check({tag, ".done_low"}, done, 64'(0));
      check({tag, ".idle_hold"}, sum, 64'(prev_sum));
    end
  endtask

  initial begin
    int n, bc, pulses;
    logic [W-1:0] rx, ry;
    logic         rc;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    prev_ovf  = 1'b0;
`endif
    step();
    step();
    check("reset.busy", busy, 64'(0));
    check("reset.done", done, 64'(0));
    check("reset.sum", sum, 64'(0));
    check("reset.cout", cout, 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("reset.ovf", ovf, 64'(0));
`endif
    rst_n = 1'b1;

    // Start on the first edge after reset release.
    do_op("basic_5a_3c", 8'h5A, 8'h3C, 1'b0);
    idle("after_basic", 2);

    do_op("ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("b2b_00_00_c1", 8'h00, 8'h00, 1'b1);
    idle("after_b2b", 1);

    do_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
    idle("after_ovf1", 1);
    do_op("ovf_80_80", 8'h80, 8'h80, 1'b0);
    idle("after_ovf2", 1);

    // A start raised mid-addition must be ignored.
    start_op(8'h11, 8'h22, 1'b0);
    step();
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n, bc);
    check("ignore.latency", 64'(n + 3), 64'(W + 1));
    check_result("ignore", 8'h11, 8'h22, 1'b0);
    pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("ignore.extra_done", 64'(pulses), 64'(0));
    check("ignore.sum_after", sum, 64'(8'h33));

    // Reset in the fourth ADD cycle aborts with no done pulse.
    start_op(8'h12, 8'h34, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("abort.busy", busy, 64'(0));
    check("abort.done", done, 64'(0));
    check("abort.sum", sum, 64'(0));
    check("abort.cout", cout, 64'(0));
    step();
    rst_n     = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    prev_ovf  = 1'b0;
`endif
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("abort.no_done", 64'(pulses), 64'(0));
    check("abort.sum_after", sum, 64'(0));
    check("abort.cout_after", cout, 64'(0));
    do_op("after_abort", 8'hA5, 8'h5B, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom);
      do_op($sformatf("rand%0d", i), rx, ry, rc);
      if ($urandom_range(0, 1) == 1) idle($sformatf("rand%0d", i), int'($urandom_range(1, 3)));
    end

    idle("final", 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
